// File: rtl/arb_pkg.sv
// Shared arbitration constants and state type for the rr_arbiter_8 slice and
// the downstream grant decoder.
package arb_pkg;
    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward modulo N_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]   enc_s;

    // Rotating the doubled vector puts req[ptr] at bit 0.
    assign dbl_s = {req, req} >> ptr;
    assign rot_s = dbl_s[N_REQ-1:0];

    // Fixed-priority encode of the rotated vector, lowest bit wins.
    always_comb begin
        enc_s = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                enc_s = IDX_W'(i);
            end else begin
                enc_s = enc_s;
            end
        end
    end

    assign found = |req;
    assign idx   = enc_s + ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with bounded grant tenure and a registered
// grant index that drives the downstream one-hot decoder.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic             found_s;
    logic [IDX_W-1:0] pick_idx_s;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    // Arbitration FSM with pointer, tenure counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            hold_cnt_r  <= {CNT_W{1'b0}};
            grant_idx   <= {IDX_W{1'b0}};
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_idx   <= pick_idx_s;
                        grant_valid <= 1'b1;
                        ptr_r       <= pick_idx_s + IDX_W'(1);
                        hold_cnt_r  <= {CNT_W{1'b0}};
                        state_r     <= GRANT;
                    end else begin
                        grant_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release and withdrawal outrank the hold limit, so a
                    // coincident limit never reports a timeout.
                    if (release_i || !req[grant_idx]) begin
                        grant_valid <= 1'b0;
                        hold_cnt_r  <= {CNT_W{1'b0}};
                        state_r     <= IDLE;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        grant_valid <= 1'b0;
                        hold_cnt_r  <= {CNT_W{1'b0}};
                        timeout     <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    hold_cnt_r  <= {CNT_W{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rr_arbiter_8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       release_i;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner, pointer, cycles of tenure so far.
    int m_ptr;
    bit m_busy;
    int m_idx;
    int m_ten;
    bit m_to;

    rr_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .release_i   (release_i),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_idx  = 0;
        m_ten  = 0;
        m_to   = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit found;
        m_to = 1'b0;
        if (!m_busy) begin
            if (req != 8'h00) begin
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && req[(m_ptr + k) % 8]) begin
                        found = 1'b1;
                        m_idx = (m_ptr + k) % 8;
                    end
                end
                m_busy = 1'b1;
                m_ptr  = (m_idx + 1) % 8;
                m_ten  = 1;
            end
        end else if (release_i || !req[m_idx]) begin
            m_busy = 1'b0;
        end else if (m_ten == MH) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
        end else begin
            m_ten++;
        end
    endtask

    task automatic compare();
        vectors++;
        if (grant_valid !== m_busy || grant_idx !== 3'(m_idx) || timeout !== m_to) begin
            miscompares++;
            $display("FAIL model t=%0t valid=%b exp %b idx=%0d exp %0d timeout=%b exp %b",
                     $time, grant_valid, m_busy, grant_idx, m_idx, timeout, m_to);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, cross one rising edge, then check.
    task automatic step(input logic [7:0] r, input logic rel);
        req       = r;
        release_i = rel;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rr;
        rst_n     = 1'b0;
        req       = 8'h00;
        release_i = 1'b0;
        do_reset();
        chk("reset_valid", int'(grant_valid), 0);
        chk("reset_idx", int'(grant_idx), 0);
        chk("reset_timeout", int'(timeout), 0);
        step(8'h00, 1'b0);

        // Fairness rotation with all lines requesting.
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0);
            chk("fair_idx", int'(grant_idx), k % 8);
            chk("fair_valid", int'(grant_valid), 1);
            step(8'hFF, 1'b1);
            chk("fair_dead", int'(grant_valid), 0);
        end
        step(8'h00, 1'b0);

        // Reset mid-grant, then a fresh arbitration from ptr 0.
        do_reset();
        step(8'h20, 1'b0);
        chk("rst_pre_idx", int'(grant_idx), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", int'(grant_valid), 0);
        chk("rst_async_idx", int'(grant_idx), 0);
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        step(8'h30, 1'b0);
        chk("rst_after_idx", int'(grant_idx), 4);
        step(8'h30, 1'b1);

        // Wrap-around: idx 5 leaves ptr at 6, then requests 0 and 1.
        step(8'h20, 1'b0);
        step(8'h20, 1'b1);
        step(8'h03, 1'b0);
        chk("wrap_idx0", int'(grant_idx), 0);
        step(8'h03, 1'b1);
        step(8'h03, 1'b0);
        chk("wrap_idx1", int'(grant_idx), 1);
        step(8'h03, 1'b1);
        step(8'h00, 1'b0);

        // Timeout after MH cycles, dead cycle, regrant of idx 3.
        step(8'h08, 1'b0);
        for (int k = 0; k < MH - 1; k++) begin
            step(8'h08, 1'b0);
            chk("to_hold_valid", int'(grant_valid), 1);
        end
        step(8'h08, 1'b0);
        chk("to_drop_valid", int'(grant_valid), 0);
        chk("to_pulse", int'(timeout), 1);
        step(8'h08, 1'b0);
        chk("to_regrant_idx", int'(grant_idx), 3);
        chk("to_regrant_valid", int'(grant_valid), 1);
        chk("to_pulse_gone", int'(timeout), 0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Release coinciding with the hold limit is a normal release.
        step(8'h08, 1'b0);
        for (int k = 0; k < MH - 1; k++) step(8'h08, 1'b0);
        step(8'h08, 1'b1);
        chk("sim_valid", int'(grant_valid), 0);
        chk("sim_timeout", int'(timeout), 0);
        step(8'h00, 1'b0);

        // Owner withdraws while another line waits.
        step(8'h04, 1'b0);
        chk("wd_idx", int'(grant_idx), 2);
        step(8'h44, 1'b0);
        step(8'h40, 1'b0);
        chk("wd_drop", int'(grant_valid), 0);
        step(8'h40, 1'b0);
        chk("wd_next_idx", int'(grant_idx), 6);
        chk("wd_next_valid", int'(grant_valid), 1);

        // Randomized traffic with runs of stable requests.
        rr = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rr = 8'($urandom) & 8'($urandom);
            step(rr, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter for eight requesters that produces a registered 3-bit grant index. The index feeds the 3-to-8 one-hot decoder stage directly downstream, and that decoder drives the per-requester grant lines. Fairness comes from a rotating priority pointer. A hold counter bounds each grant's tenure, so no requester can monopolise the shared resource.

## Interface
- `MAX_HOLD`, 16, maximum grant tenure in cycles; legal range 2..31.
- `CNT_W`, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  8  request lines; bit k is requester k; level-sensitive, sampled only at clock edges.
- `release_i`  in  1  current owner finishes its tenure; honoured only in GRANT.
- `grant_idx`  out  3  registered index of the current owner; this is the decoder's select input.
- `grant_valid`  out  1  high while `grant_idx` names a valid owner; qualifies the decoder output.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: state IDLE, `ptr`=0, `hold_cnt`=0, `grant_idx`=3'b000, `grant_valid`=0, `timeout`=0.
- `ptr` (3 bits) is the highest-priority index for the next arbitration.
- The search order is `ptr`, `ptr`+1, …, `ptr`+7, all modulo 8. Index 7 wraps to 0.
- State IDLE:
  - If `req` is nonzero, the winner is the first set bit in search order.
  - On that edge: `grant_idx`←winner, `grant_valid`←1, `ptr`←winner+1 (mod 8), `hold_cnt`←0, then go to GRANT.
  - If `req`=0, stay in IDLE with `grant_valid`=0. `grant_idx` keeps its last value.
- State GRANT:
  - `hold_cnt` increments every cycle.
  - Exit to IDLE on the first edge where any of these holds, checked in priority order:
    - (a) `release_i`=1;
    - (b) `req[grant_idx]`=0, i.e. the owner withdrew;
    - (c) `hold_cnt`=MAX_HOLD-1.
  - On exit: `grant_valid`←0 and `hold_cnt`←0.
  - `timeout`←1 for one cycle only when (c) alone causes the exit.
- If (a) or (b) coincides with (c), the exit is a normal release and `timeout` stays 0.
- After every exit there is exactly one dead IDLE cycle with `grant_valid`=0 before the next grant. This gives the decoder a clean break-before-make.
- A revoked owner that keeps requesting gets no special treatment. It is rearbitrated normally and sits at lowest priority because `ptr` has already moved past it.
- Reset asserted mid-grant: all outputs drop to their reset values immediately and asynchronously. The next grant after release starts from `ptr`=0.

## Timing
- Request to grant: `req` set at edge N with state IDLE gives `grant_valid`=1 and valid `grant_idx` after edge N+1. Latency is one cycle.
- Release to drop: `release_i` at edge M gives `grant_valid`=0 after edge M+1. The earliest next grant is after edge M+2.
- Maximum tenure: `grant_valid` stays high for at most MAX_HOLD consecutive cycles. `timeout` is high in the first cycle after revocation.
- `grant_idx` and `grant_valid` change only on the same edge and are both registered. No combinational path runs from `req` to any output.
- Worst-case wait for any persistently requesting line: 7 × (MAX_HOLD+1) cycles.

## Structure
- Shared package `arb_pkg` holds:
  - `N_REQ`=8 and `IDX_W`=3;
  - the state enum {IDLE, GRANT};
  - the default `MAX_HOLD`.
- The downstream decoder imports `IDX_W` from the same package.
- One sub-module, `rr_pick`: purely combinational.
  - Inputs: `req[7:0]` and `ptr[2:0]`.
  - Outputs: `found` and `idx[2:0]`.
  - Implementation: rotate right by `ptr`, fixed-priority encode, add `ptr` back mod 8.
- Top level holds the FSM, `ptr`, `hold_cnt`, and the output registers.

## Test plan
- Reset mid-grant: grant idx 5, assert `rst_n`=0 asynchronously between edges → `grant_valid`=0 and `grant_idx`=0 immediately; after release, `req`=8'h30 → grant idx 4.
- Fairness rotation: hold `req`=8'hFF, pulse `release_i` one cycle after each grant → `grant_idx` sequence 0,1,2,…,7,0, with one dead cycle between grants.
- Wrap-around: `ptr`=6, `req`=8'b0000_0011 → grant idx 0, then `ptr`=1; next arbitration with same `req` → idx 1.
- Timeout: MAX_HOLD=4, `req`=8'h08 held, no release → `grant_valid` high for exactly 4 cycles, `timeout` pulses once, then idx 3 is regranted after the dead cycle.
- Simultaneous release and limit: `release_i`=1 on the cycle `hold_cnt`=MAX_HOLD-1 → `grant_valid` drops and `timeout` stays 0.
- Owner withdraws: grant idx 2, drop `req[2]` while `req[6]`=1 → `grant_valid`=0 next cycle, then idx 6 is granted one cycle later.
